// File: rtl/hex_bus_display.sv
// hex_bus_display: consumer of the 32-bit hex5_0bus PIO export.
// Filters the bus for stability, keeps a committed shadow copy and drives
// six active-low 7-segment digits with per-digit blink, global blank and a
// 4-step brightness PWM.
// Optional build macro HEX_LAMP_TEST_EN: lights every segment for
// LAMP_CYCLES cycles after reset release.
module hex_bus_display #(
   parameter int STABLE_CYCLES = 4,
   parameter int BLINK_HALF    = 12500000,
   parameter int PWM_DIV       = 1024
`ifdef HEX_LAMP_TEST_EN
   ,
   parameter int LAMP_CYCLES   = 50000000
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] hex_bus,
   input  logic [1:0]  brightness,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        updated
);

   localparam int SCW = $clog2(STABLE_CYCLES + 1);
   localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int PDW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [31:0]      bus_q, bus_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [SCW-1:0]   stable_cnt_q, stable_cnt_d;
   logic             updated_q, updated_d;
   logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [PDW-1:0]   pwm_div_cnt_q, pwm_div_cnt_d;
   logic [1:0]       pwm_step_q, pwm_step_d;
   logic [5:0][6:0]  hex_q, hex_d;
   logic             seg_on;
   logic             lamp_on;

   // Nibble to active-low segment pattern (bit0 = a .. bit6 = g).
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0: seg_decode = 7'h40;
         4'h1: seg_decode = 7'h79;
         4'h2: seg_decode = 7'h24;
         4'h3: seg_decode = 7'h30;
         4'h4: seg_decode = 7'h19;
         4'h5: seg_decode = 7'h12;
         4'h6: seg_decode = 7'h02;
         4'h7: seg_decode = 7'h78;
         4'h8: seg_decode = 7'h00;
         4'h9: seg_decode = 7'h10;
         4'hA: seg_decode = 7'h08;
         4'hB: seg_decode = 7'h03;
         4'hC: seg_decode = 7'h46;
         4'hD: seg_decode = 7'h21;
         4'hE: seg_decode = 7'h06;
         default: seg_decode = 7'h0E;
      endcase
   endfunction

   // Stability filter: commit the sampled word once it has been steady long enough.
   always_comb begin
      bus_d        = hex_bus & 32'h7FFF_FFFF;
      stable_cnt_d = stable_cnt_q;
      shadow_d     = shadow_q;
      updated_d    = 1'b0;
      if (bus_d != bus_q) begin
         stable_cnt_d = '0;
      end else begin
         if (stable_cnt_q < SCW'(STABLE_CYCLES)) stable_cnt_d = stable_cnt_q + SCW'(1);
         if (stable_cnt_q == SCW'(STABLE_CYCLES - 1)) begin
            shadow_d  = bus_q;
            updated_d = (bus_q != shadow_q);
         end
      end
   end

   // Free-running blink and PWM timers; commits never disturb them.
   always_comb begin
      blink_cnt_d   = blink_cnt_q + BCW'(1);
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BCW'(BLINK_HALF - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end
      pwm_div_cnt_d = pwm_div_cnt_q + PDW'(1);
      pwm_step_d    = pwm_step_q;
      if (pwm_div_cnt_q == PDW'(PWM_DIV - 1)) begin
         pwm_div_cnt_d = '0;
         pwm_step_d    = pwm_step_q + 2'd1;
      end
   end

   assign seg_on = (pwm_step_q <= brightness);

`ifdef HEX_LAMP_TEST_EN
   localparam int LCW = $clog2(LAMP_CYCLES + 1);
   logic [LCW-1:0] lamp_cnt_q;

   // Lamp-test window: counts down from reset release, then stays at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               lamp_cnt_q <= LCW'(LAMP_CYCLES);
      else if (lamp_cnt_q != '0)  lamp_cnt_q <= lamp_cnt_q - LCW'(1);
   end

   assign lamp_on = (lamp_cnt_q != '0);
`else
   assign lamp_on = 1'b0;
`endif

   // Per-digit output mux: lamp test, blank, blink, PWM, then decoded nibble.
   always_comb begin
      hex_d = {6{7'h7F}};
      for (int k = 0; k < 6; k++) begin
         if (lamp_on)                                 hex_d[k] = 7'h00;
         else if (shadow_q[30])                       hex_d[k] = 7'h7F;
         else if (shadow_q[24 + k] && !blink_phase_q) hex_d[k] = 7'h7F;
         else if (!seg_on)                            hex_d[k] = 7'h7F;
         else                                         hex_d[k] = seg_decode(shadow_q[4*k +: 4]);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_q         <= '0;
         shadow_q      <= '0;
         stable_cnt_q  <= '0;
         updated_q     <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         pwm_div_cnt_q <= '0;
         pwm_step_q    <= '0;
         hex_q         <= {6{7'h7F}};
      end else begin
         bus_q         <= bus_d;
         shadow_q      <= shadow_d;
         stable_cnt_q  <= stable_cnt_d;
         updated_q     <= updated_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         pwm_div_cnt_q <= pwm_div_cnt_d;
         pwm_step_q    <= pwm_step_d;
         hex_q         <= hex_d;
      end
   end

   assign hex0    = hex_q[0];
   assign hex1    = hex_q[1];
   assign hex2    = hex_q[2];
   assign hex3    = hex_q[3];
   assign hex4    = hex_q[4];
   assign hex5    = hex_q[5];
   assign updated = updated_q;

endmodule
